// File: rtl/control_unit.sv
// Hardwired multi-cycle control sequencer for the single-bus CPU: fetch in T0-T2,
// per-opcode execute in T3-T7, HALT until reset. Strobes decode from state and opcode.
module control_unit #(
    parameter int unsigned REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_SIZE-1:0] ir,
    input  logic                con_ff,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic                r_in,
    output logic                r_out,
    output logic                ba_out,
    output logic                hi_in,
    output logic                hi_out,
    output logic                lo_in,
    output logic                lo_out,
    output logic                pc_in,
    output logic                pc_out,
    output logic                ir_in,
    output logic                z_in,
    output logic                z_high_out,
    output logic                z_low_out,
    output logic                c_out,
    output logic                y_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read,
    output logic                write,
    output logic                con_in,
    output logic [3:0]          alu_op,
    output logic                inc_pc,
    output logic                run
);

    localparam int unsigned OPC_W = 5;
    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_MUL = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_DIV = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_NEG = ALU_W'(10);
    localparam logic [ALU_W-1:0] ALU_NOT = ALU_W'(11);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY,
        C_BR, C_JR, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_e;

    state_e               state_q;
    state_e               state_d;
    cls_e                 cls;
    logic [OPC_W-1:0]     opc;
    logic [ALU_W-1:0]     op_alu;
    logic                 unused_ir;

    assign opc       = ir[REG_SIZE-1 -: OPC_W];
    assign unused_ir = ^ir[REG_SIZE-OPC_W-1:0];

    // Instruction class and the ALU operation the opcode asks for
    always_comb begin
        cls    = C_NOP;
        op_alu = ALU_ADD;
        case (opc)
            5'd0:                      cls = C_LD;
            5'd1:                      cls = C_LDI;
            5'd2:                      cls = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6,
            5'd7, 5'd8, 5'd9, 5'd10: begin
                cls    = C_ALU;
                op_alu = ALU_W'(opc - OPC_W'(3));
            end
            5'd11: begin cls = C_IMM;    op_alu = ALU_ADD; end
            5'd12: begin cls = C_IMM;    op_alu = ALU_AND; end
            5'd13: begin cls = C_IMM;    op_alu = ALU_OR;  end
            5'd14: begin cls = C_MULDIV; op_alu = ALU_MUL; end
            5'd15: begin cls = C_MULDIV; op_alu = ALU_DIV; end
            5'd16: begin cls = C_UNARY;  op_alu = ALU_NEG; end
            5'd17: begin cls = C_UNARY;  op_alu = ALU_NOT; end
            5'd18:                     cls = C_BR;
            5'd19:                     cls = C_JR;
            5'd20:                     cls = C_MFHI;
            5'd21:                     cls = C_MFLO;
            5'd23:                     cls = C_HALT;
            default:                   cls = C_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step and strobe decode; reset blanks every output in the same cycle
    always_comb begin
        state_d    = state_q;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        r_in       = 1'b0;
        r_out      = 1'b0;
        ba_out     = 1'b0;
        hi_in      = 1'b0;
        hi_out     = 1'b0;
        lo_in      = 1'b0;
        lo_out     = 1'b0;
        pc_in      = 1'b0;
        pc_out     = 1'b0;
        ir_in      = 1'b0;
        z_in       = 1'b0;
        z_high_out = 1'b0;
        z_low_out  = 1'b0;
        c_out      = 1'b0;
        y_in       = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        con_in     = 1'b0;
        alu_op     = ALU_ADD;
        inc_pc     = 1'b0;
        run        = 1'b0;
        if (!reset) begin
            run = (state_q != S_HALT);
            case (state_q)
                S_T0: begin
                    pc_out  = 1'b1;
                    inc_pc  = 1'b1;
                    z_in    = 1'b1;
                    mar_in  = 1'b1;
                    state_d = S_T1;
                end
                S_T1: begin
                    z_low_out = 1'b1;
                    pc_in     = 1'b1;
                    read      = 1'b1;
                    mdr_in    = 1'b1;
                    state_d   = S_T2;
                end
                S_T2: begin
                    mdr_out = 1'b1;
                    ir_in   = 1'b1;
                    case (cls)
                        C_HALT:  state_d = S_HALT;
                        C_NOP:   state_d = S_T0;
                        default: state_d = S_T3;
                    endcase
                end
                S_T3: begin
                    state_d = S_T4;
                    case (cls)
                        C_LD, C_LDI, C_ST: begin
                            grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                        end
                        C_ALU, C_IMM: begin
                            grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                        end
                        C_MULDIV: begin
                            gra = 1'b1; r_out = 1'b1; y_in = 1'b1;
                        end
                        C_UNARY: begin
                            grb = 1'b1; r_out = 1'b1; alu_op = op_alu; z_in = 1'b1;
                        end
                        C_BR: begin
                            gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
                        end
                        C_JR: begin
                            gra = 1'b1; r_out = 1'b1; pc_in = 1'b1;
                            state_d = S_T0;
                        end
                        C_MFHI: begin
                            hi_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                            state_d = S_T0;
                        end
                        C_MFLO: begin
                            lo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                            state_d = S_T0;
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T4: begin
                    state_d = S_T5;
                    case (cls)
                        C_LD, C_LDI, C_ST: begin
                            c_out = 1'b1; z_in = 1'b1;
                        end
                        C_ALU: begin
                            grc = 1'b1; r_out = 1'b1; alu_op = op_alu; z_in = 1'b1;
                        end
                        C_IMM: begin
                            c_out = 1'b1; alu_op = op_alu; z_in = 1'b1;
                        end
                        C_MULDIV: begin
                            grb = 1'b1; r_out = 1'b1; alu_op = op_alu; z_in = 1'b1;
                        end
                        C_UNARY: begin
                            z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                            state_d = S_T0;
                        end
                        C_BR: begin
                            pc_out = 1'b1; y_in = 1'b1;
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T5: begin
                    state_d = S_T6;
                    case (cls)
                        C_LD, C_ST: begin
                            z_low_out = 1'b1; mar_in = 1'b1;
                        end
                        C_LDI, C_ALU, C_IMM: begin
                            z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                            state_d = S_T0;
                        end
                        C_MULDIV: begin
                            z_low_out = 1'b1; lo_in = 1'b1;
                        end
                        C_BR: begin
                            c_out = 1'b1; z_in = 1'b1;
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T6: begin
                    state_d = S_T0;
                    case (cls)
                        C_LD: begin
                            read = 1'b1; mdr_in = 1'b1;
                            state_d = S_T7;
                        end
                        C_ST: begin
                            gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
                            state_d = S_T7;
                        end
                        C_MULDIV: begin
                            z_high_out = 1'b1; hi_in = 1'b1;
                        end
                        C_BR: begin
                            z_low_out = con_ff;
                            pc_in     = con_ff;
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T7: begin
                    state_d = S_T0;
                    case (cls)
                        C_LD: begin
                            mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                        end
                        C_ST:    write = 1'b1;
                        default: state_d = S_T0;
                    endcase
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_T0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction's expected strobe sequence is built from a
// per-opcode micro-step listing and compared cycle by cycle, with random and directed programs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        con_ff;
    logic gra, grb, grc, r_in, r_out, ba_out, hi_in, hi_out, lo_in, lo_out;
    logic pc_in, pc_out, ir_in, z_in, z_high_out, z_low_out, c_out, y_in;
    logic mar_in, mdr_in, mdr_out, read, write, con_in, inc_pc, run;
    logic [3:0] alu_op;

    always #5 clk = ~clk;

    control_unit #(.REG_SIZE(32)) dut (
        .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
        .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .z_in(z_in),
        .z_high_out(z_high_out), .z_low_out(z_low_out), .c_out(c_out), .y_in(y_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .write(write),
        .con_in(con_in), .alu_op(alu_op), .inc_pc(inc_pc), .run(run)
    );

    // Observed control word: {run, alu_op, strobes}
    logic [29:0] obs;
    assign obs = {run, alu_op, inc_pc, con_in, write, read, mdr_out, mdr_in, mar_in, y_in,
                  c_out, z_low_out, z_high_out, z_in, ir_in, pc_out, pc_in, lo_out, lo_in,
                  hi_out, hi_in, ba_out, r_out, r_in, grc, grb, gra};

    localparam logic [29:0] GRA   = 30'd1 << 0;
    localparam logic [29:0] GRB   = 30'd1 << 1;
    localparam logic [29:0] GRC   = 30'd1 << 2;
    localparam logic [29:0] RIN   = 30'd1 << 3;
    localparam logic [29:0] ROUT  = 30'd1 << 4;
    localparam logic [29:0] BAO   = 30'd1 << 5;
    localparam logic [29:0] HIIN  = 30'd1 << 6;
    localparam logic [29:0] HIO   = 30'd1 << 7;
    localparam logic [29:0] LOIN  = 30'd1 << 8;
    localparam logic [29:0] LOO   = 30'd1 << 9;
    localparam logic [29:0] PCI   = 30'd1 << 10;
    localparam logic [29:0] PCO   = 30'd1 << 11;
    localparam logic [29:0] IRIN  = 30'd1 << 12;
    localparam logic [29:0] ZIN   = 30'd1 << 13;
    localparam logic [29:0] ZHO   = 30'd1 << 14;
    localparam logic [29:0] ZLO   = 30'd1 << 15;
    localparam logic [29:0] CO    = 30'd1 << 16;
    localparam logic [29:0] YIN   = 30'd1 << 17;
    localparam logic [29:0] MARIN = 30'd1 << 18;
    localparam logic [29:0] MDRIN = 30'd1 << 19;
    localparam logic [29:0] MDRO  = 30'd1 << 20;
    localparam logic [29:0] READ  = 30'd1 << 21;
    localparam logic [29:0] WRITE = 30'd1 << 22;
    localparam logic [29:0] CONIN = 30'd1 << 23;
    localparam logic [29:0] INCPC = 30'd1 << 24;
    localparam logic [29:0] RUN   = 30'd1 << 29;

    int n_assert = 0;
    int n_fail   = 0;
    logic [29:0] exp_q[$];

    function automatic logic [29:0] alu(input int op);
        int code;
        if (op >= 3 && op <= 10) code = op - 3;
        else if (op == 11) code = 0;
        else if (op == 12) code = 2;
        else if (op == 13) code = 3;
        else if (op >= 14 && op <= 17) code = op - 6;
        else code = 0;
        return 30'(code) << 25;
    endfunction

    function automatic void push(input logic [29:0] m);
        exp_q.push_back(m | RUN);
    endfunction

    // Micro-step listing: fetch then the opcode's execute steps
    function automatic void build(input int op, input bit con);
        exp_q.delete();
        push(PCO | INCPC | ZIN | MARIN);
        push(ZLO | PCI | READ | MDRIN);
        push(MDRO | IRIN);
        if (op <= 2) begin
            push(GRB | BAO | YIN);
            push(CO | ZIN);
            if (op == 1) begin
                push(ZLO | GRA | RIN);
            end else begin
                push(ZLO | MARIN);
                if (op == 0) begin
                    push(READ | MDRIN);
                    push(MDRO | GRA | RIN);
                end else begin
                    push(GRA | ROUT | MDRIN);
                    push(WRITE);
                end
            end
        end else if (op <= 13) begin
            push(GRB | ROUT | YIN);
            push(((op <= 10) ? (GRC | ROUT) : CO) | ZIN | alu(op));
            push(ZLO | GRA | RIN);
        end else if (op <= 15) begin
            push(GRA | ROUT | YIN);
            push(GRB | ROUT | ZIN | alu(op));
            push(ZLO | LOIN);
            push(ZHO | HIIN);
        end else if (op <= 17) begin
            push(GRB | ROUT | ZIN | alu(op));
            push(ZLO | GRA | RIN);
        end else if (op == 18) begin
            push(GRA | ROUT | CONIN);
            push(PCO | YIN);
            push(CO | ZIN);
            push(con ? (ZLO | PCI) : 30'd0);
        end else if (op == 19) begin
            push(GRA | ROUT | PCI);
        end else if (op == 20) begin
            push(HIO | GRA | RIN);
        end else if (op == 21) begin
            push(LOO | GRA | RIN);
        end
    endfunction

    task automatic chk(input string tag, input logic [29:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Entered just after an edge with the DUT in T0; leaves it the same way
    task automatic run_instr(input int op, input bit con, input int abort_at);
        build(op, con);
        ir     = {5'(op), 27'($urandom)};
        con_ff = con;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk($sformatf("abort_op%0d_t%0d", op, i), 30'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            chk($sformatf("op%0d_t%0d_con%0d", op, i, con), exp_q[i]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        ir     = '0;
        con_ff = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_idle", 30'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(3, 1'b0, -1);
        run_instr(0, 1'b1, -1);
        run_instr(2, 1'b0, -1);
        run_instr(18, 1'b1, -1);
        run_instr(18, 1'b0, -1);
        run_instr(14, 1'b0, -1);
        run_instr(27, 1'b1, -1);
        for (int op = 0; op < 32; op++) begin
            if (op != 23) run_instr(op, 1'(op & 1), -1);
        end

        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(31));
            if (op == 23) op = 22;
            run_instr(op, 1'($urandom_range(1)), -1);
        end

        run_instr(2, 1'b0, 7);
        run_instr(0, 1'b1, 7);
        run_instr(4, 1'b0, 5);
        run_instr(14, 1'b0, 6);

        run_instr(23, 1'b0, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("halt_c%0d", c), 30'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("halt_reset", 30'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(27, 1'b0, -1);
        run_instr(10, 1'b1, -1);
        run_instr(22, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
